// File: rtl/subneg_pkg.sv
// Shared types and constants for the SUBNEG sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package subneg_pkg;

    // One state per cycle of an instruction, plus the terminal HALT state.
    typedef enum logic [3:0] {
        FA,     // present pc
        FB,     // present pc+1, capture A
        FC,     // present pc+2, capture B
        RA,     // present A,    capture C
        RB,     // present B,    capture mem[A]
        EX,     // hold B,       capture mem[B]
        WB,     // write mem[B] - mem[A] back to B
        UPD,    // load pc from the external PC-select mux
        HALT    // parked until reset
    } state_t;

    localparam int INSTR_WORDS  = 3;
    localparam int INSTR_CYCLES = 8;

endpackage

// File: rtl/subneg_ctrl.sv
// SUBNEG sequencer: fetches (A,B,C), writes mem[B]-mem[A] to B, branches to C on negative.
// Latency: 8 cycles per instruction (FA..UPD); HALT is sticky until rst.
// Backpressure: none; memory has fixed 1-cycle read latency and the PC mux is combinational.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   mem_addr/mem_rdata synchronous single-port memory read (data arrives one cycle later)
//   mem_wdata/mem_we   memory write, only asserted in WB
//   pc_inc, br_target  candidate next PCs driven to the external mux (in1, in2)
//   br_sel, pc_next    mux select out, mux result back in (sampled in UPD)
//   pc, instr_done     current instruction address, retire pulse
//   halted             high while parked in HALT
module subneg_ctrl
    import subneg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] HALT_ADDR = '1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    output logic [WIDTH-1:0] pc_inc,
    output logic [WIDTH-1:0] br_target,
    output logic             br_sel,
    input  logic [WIDTH-1:0] pc_next,
    output logic [WIDTH-1:0] pc,
    output logic             instr_done,
    output logic             halted
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_rc;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_br_sel;

    logic [WIDTH-1:0] w_pc1;
    logic [WIDTH-1:0] w_pc2;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_mem_addr;
    logic [WIDTH-1:0] w_mem_wdata;
    logic             w_mem_we;

    // Plain WIDTH-bit adds give the modulo-2^WIDTH wrap for free.
    assign w_pc1 = r_pc + WIDTH'(1);
    assign w_pc2 = r_pc + WIDTH'(2);
    assign w_res = r_opb - r_opa;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FA;
            r_pc     <= RESET_PC;
            r_ra     <= '0;
            r_rb     <= '0;
            r_rc     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_br_sel <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Each capture takes the word addressed in the previous state.
            case (r_state)
                FB:      r_ra     <= mem_rdata;
                FC:      r_rb     <= mem_rdata;
                RA:      r_rc     <= mem_rdata;
                RB:      r_opa    <= mem_rdata;
                EX:      r_opb    <= mem_rdata;
                WB:      r_br_sel <= w_res[WIDTH-1];
                UPD:     r_pc     <= pc_next;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_addr  = r_pc;
        w_mem_we    = 1'b0;
        w_mem_wdata = '0;
        case (r_state)
            FA: begin
                w_mem_addr  = r_pc;
                w_state_nxt = FB;
            end
            FB: begin
                w_mem_addr  = w_pc1;
                w_state_nxt = FC;
            end
            FC: begin
                w_mem_addr  = w_pc2;
                w_state_nxt = RA;
            end
            RA: begin
                w_mem_addr  = r_ra;
                w_state_nxt = RB;
            end
            RB: begin
                w_mem_addr  = r_rb;
                w_state_nxt = EX;
            end
            EX: begin
                w_mem_addr  = r_rb;
                w_state_nxt = WB;
            end
            WB: begin
                w_mem_addr  = r_rb;
                w_mem_we    = 1'b1;
                w_mem_wdata = w_res;
                w_state_nxt = UPD;
            end
            UPD: begin
                w_state_nxt = (pc_next == HALT_ADDR) ? HALT : FA;
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = FA;
            end
        endcase
    end

    assign mem_addr   = w_mem_addr;
    assign mem_wdata  = w_mem_wdata;
    // Reset must win over a coincident WB so an aborted instruction never writes.
    assign mem_we     = w_mem_we & ~rst;
    assign pc_inc     = r_pc + WIDTH'(INSTR_WORDS);
    assign br_target  = r_rc;
    assign br_sel     = r_br_sel;
    assign pc         = r_pc;
    assign instr_done = (r_state == UPD);
    assign halted     = (r_state == HALT);

endmodule

// File: doc/subneg_ctrl.md
Name: subneg_ctrl

Overview:
- Multi-cycle SUBNEG sequencer. Fetches a three-word instruction (A, B, C) from a synchronous single-port memory and executes mem[B] <= mem[B] - mem[A]. Branches to C when the result is negative, otherwise advances to PC+3.
- Directly upstream of the PC-select `mux`: drives its in1 (pc_inc), in2 (br_target) and sel (br_sel), and consumes its out as pc_next.

Parameters:
- WIDTH, 8, data and address width in bits; memory depth is 2^WIDTH words.
- RESET_PC, 0, PC value loaded on reset.
- HALT_ADDR, 2^WIDTH-1 (all ones), PC value that stops execution.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_addr  out  WIDTH  memory address.
- mem_rdata  in  WIDTH  read data for the address presented on the previous cycle (1-cycle latency).
- mem_wdata  out  WIDTH  write data.
- mem_we  out  1  write enable; writes mem[mem_addr] at the edge.
- pc_inc  out  WIDTH  (pc+3) mod 2^WIDTH, to mux in1.
- br_target  out  WIDTH  registered C operand, to mux in2.
- br_sel  out  1  1 = take branch, to mux sel.
- pc_next  in  WIDTH  mux output.
- pc  out  WIDTH  current instruction address.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- halted  out  1  high while in HALT.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC; state=FA.
  - ra, rb, rc, opa, opb, br_sel = 0.
  - instr_done=0, halted=0, mem_we=0.
  - Reset mid-instruction aborts it. mem_we is forced 0 in any cycle where rst=1, so a WB coincident with reset does not write.
- FSM: FA→FB→FC→RA→RB→EX→WB→UPD→(FA | HALT). Each state lasts exactly 1 cycle, so an instruction takes 8 cycles.
  - FA: mem_addr=pc.
  - FB: mem_addr=pc+1; ra<=mem_rdata.
  - FC: mem_addr=pc+2; rb<=mem_rdata.
  - RA: mem_addr=ra; rc<=mem_rdata.
  - RB: mem_addr=rb; opa<=mem_rdata.
  - EX: mem_addr=rb; opb<=mem_rdata.
  - WB: mem_addr=rb, mem_we=1, mem_wdata=res where res=(opb-opa) mod 2^WIDTH; br_sel<=res[WIDTH-1].
  - UPD: pc<=pc_next; instr_done=1. Go to HALT if pc_next==HALT_ADDR, else FA.
  - HALT: halted=1, mem_we=0, all registers hold. Exit only via rst.
- Unless stated above, mem_we=0 and mem_wdata=0.
- Address arithmetic: pc+1, pc+2 and pc+3 wrap modulo 2^WIDTH (pc=0xFE → fetch addresses 0xFE, 0xFF, 0x00; pc_inc=0x01).
- Sign rule: negative means res MSB=1 only.
  - res=0 is not negative.
  - No overflow detection: 0x80-0x01=0x7F, so no branch.
- br_target=rc, valid from RA+1 onward. br_sel is stable during UPD. The external mux is combinational, so pc_next is sampled in UPD.
- A=B aliasing: res=0, so no branch.
- B inside the current instruction (self-modifying code): the write takes effect and is seen on the next fetch.
- HALT_ADDR reached by either a branch or a sequential increment halts.

Decomposition:
- subneg_pkg holds:
  - typedef enum logic [3:0] state_t {FA,FB,FC,RA,RB,EX,WB,UPD,HALT};
  - constant INSTR_WORDS=3;
  - constant INSTR_CYCLES=8.
- No sub-module inside subneg_ctrl. The PC-select mux stays external as existing `mux`. An integration wrapper, subneg_core (ctrl + mux + memory model), serves as the bench top.

Test Plan:
1. Reset then release; memory: mem[0..2]={10,11,20}, mem[10]=3, mem[11]=5 → cycle 7 writes mem[11]=2, br_sel=0. At UPD pc_next=3 and instr_done pulses; pc=3 afterwards.
2. Same instruction with mem[10]=7, mem[11]=5 → mem[11]=0xFE, br_sel=1, pc=20 after UPD.
3. Boundary results: mem[A]=mem[B]=9 → res=0, no branch. mem[B]=0x80, mem[A]=0x01 → res=0x7F, no branch.
4. Wrap: RESET_PC=0xFE, instruction bytes at 0xFE, 0xFF, 0x00 → mem_addr sequence 0xFE, 0xFF, 0x00; pc_inc=0x01.
5. Halt: C=0xFF with a negative result → halted=1 from the cycle after UPD. mem_we stays 0 for 20 cycles; rst then restarts at RESET_PC.
6. Reset asserted in the WB cycle → no write to mem[B]; next cycle state=FA, pc=RESET_PC, all outputs at reset values.
